// File: rtl/cdc_cmd_sender_if.sv
// Command-side and CDC-side handshake bundle for cdc_cmd_sender.
// The slave modport is the sender's view; the master modport drives commands and the ack.
interface cdc_cmd_sender_if #(
  parameter int DATA_W = 32
);
  logic              inValid;
  logic              inReady;
  logic [DATA_W-1:0] inData;
  logic              reqA;
  logic [DATA_W-1:0] dataA;
  logic              ackInA;

  modport slave (
    input  inValid, inData, ackInA,
    output inReady, reqA, dataA
  );

  modport master (
    output inValid, inData, ackInA,
    input  inReady, reqA, dataA
  );
endinterface

// File: rtl/cdc_cmd_sender.sv
// Clock-A launcher for the handshake bit CDC: queues commands in a small FIFO and
// issues each one as a held data word plus a 4-phase request level.
module cdc_cmd_sender #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                   clockA,
  input  logic                   resetA,
  cdc_cmd_sender_if.slave        cmd,
  output logic                   busy,
  output logic                   donePulse,
  output logic [CNT_W-1:0]       doneCount,
  output logic [$clog2(DEPTH):0] fifoLevel,
  input  logic                   errClr,
  output logic                   protoErr,
  output logic                   timeoutErr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  // REQ-cycle counter stops at TIMEOUT so a long stall cannot wrap and re-trigger.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    if (v == TW'(TIMEOUT)) return v;
    return v + TW'(1);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  state_t            state_q;
  logic              reqA_q, busy_q, done_q, proto_q, tmo_q;
  logic [DATA_W-1:0] dataA_q;
  logic [CNT_W-1:0]  doneCount_q;
  logic [TW-1:0]     tcnt_q;
  logic              full, empty, push, pop, proto_set, tmo_set;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign push      = cmd.inValid & ~full;
  assign pop       = (state_q == S_IDLE) & ~empty;
  assign proto_set = (state_q == S_IDLE) & cmd.ackInA;
  assign tmo_set   = (TIMEOUT != 0) && (state_q == S_REQ) && (tcnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage carries no reset; only pointers and occupancy are control state.
  always_ff @(posedge clockA) begin
    if (push) mem_q[wr_ptr_q] <= cmd.inData;
  end

  always_ff @(posedge clockA or negedge resetA) begin
    if (!resetA) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clockA or negedge resetA) begin
    if (!resetA) begin
      state_q     <= S_IDLE;
      reqA_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dataA_q     <= '0;
      doneCount_q <= '0;
      tcnt_q      <= '0;
      proto_q     <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_REQ;
            reqA_q  <= 1'b1;
            busy_q  <= 1'b1;
            dataA_q <= mem_q[rd_ptr_q];
            tcnt_q  <= '0;
          end
        end
        S_REQ: begin
          tcnt_q <= sat_inc(tcnt_q);
          if (cmd.ackInA) begin
            state_q <= S_WAIT;
            reqA_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (!cmd.ackInA) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            doneCount_q <= doneCount_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A setting event in the same cycle as errClr keeps the flag set.
      proto_q <= proto_set | (proto_q & ~errClr);
      tmo_q   <= tmo_set   | (tmo_q   & ~errClr);
    end
  end

  assign cmd.inReady = ~full;
  assign cmd.reqA    = reqA_q;
  assign cmd.dataA   = dataA_q;
  assign busy        = busy_q;
  assign donePulse   = done_q;
  assign doneCount   = doneCount_q;
  assign fifoLevel   = level_q;
  assign protoErr    = proto_q;
  assign timeoutErr  = tmo_q;
endmodule
